uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: the counterpart stage that consumes the line driven by `uart_tx` (8N1, LSB first, idle high). It synchronises the incoming line, detects and validates start bits with a 16x oversampling tick, shifts in data bits, checks the stop bit, and presents each received byte through a one-deep valid/ready holding register. Overrun and framing errors are flagged with single-cycle pulses.

## Interface
- `CLOCK_FREQ`, 16000000: system clock frequency in Hz.
- `BAUD`, 9600: line bit rate.
- `WIDTH`, 8: data bits per frame.
- `OVERSAMPLE`, 16: ticks per bit time; even, ≥ 8.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx_in`  input  1  serial line, asynchronous to `clk`.
- `data_out`  output  WIDTH  received byte; stable while `data_valid` is high.
- `data_valid`  output  1  holding register full.
- `data_ready`  input  1  consumer accepts; transfer occurs when `data_valid & data_ready`.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low.
- `overrun`  output  1  one-cycle pulse when a good frame completes while `data_valid` is still high.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Input path: 2-FF synchroniser on `rx_in`; both flops reset to 1. All decisions use the synchronised line `rx_s`.
- Tick generator: `DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE)` (integer division; 104 at defaults). Counter width `$clog2(DIV)+1`. Emits a one-clock `tick` when the count reaches `DIV-1`, then wraps to 0. The counter is cleared to 0 on the IDLE→START transition so that ticks are phase-aligned to the start edge.
- Tick count `tcnt` (width `$clog2(OVERSAMPLE)`) and bit index `bcnt` (width `$clog2(WIDTH)+1`).
- FSM:
  - IDLE: wait for `rx_s==0`; on detection clear the divider and `tcnt`, then go to START.
  - START: at tick `OVERSAMPLE/2-1` (mid start bit), if the sample is 0, clear `tcnt` and `bcnt` and go to DATA; otherwise go to IDLE (glitch rejection, no flags).
  - DATA: every `OVERSAMPLE` ticks (mid-bit), shift the sample into the MSB of the shift register (right shift, so the LSB arrives first). After `WIDTH` samples go to STOP.
  - STOP: at mid stop bit, a sample of 1 ends a good frame; go to IDLE. A sample of 0 pulses `frame_err`, discards the byte, and goes to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE.
- Good frame:
  - If `data_valid` is 0, load `data_out` and set `data_valid`.
  - If `data_valid` is 1 and `data_ready` is also 1 in the same cycle, the accept and the load both occur and `data_valid` stays 1 with the new byte. This is not an overrun.
  - If `data_valid` is 1 and `data_ready` is 0, keep the old byte, drop the new one, and pulse `overrun`.
- `data_valid` clears in the cycle after an accept unless a reload occurs in that same cycle.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, synchroniser=11.
- `rst` asserted mid-frame aborts immediately. After release, the block waits in IDLE for the next low level. A line held low at release is treated as a start bit.
- Start-edge recognition: 2 clocks after `rx_in` falls (synchroniser delay).
- Latency: `data_valid` rises 1 clock after the stop-bit sample point, i.e. about `(WIDTH+1.5)*OVERSAMPLE*DIV + 3` clocks after the `rx_in` falling edge. At defaults this is 15811 clocks.
- `frame_err` and `overrun` are exactly 1 clock wide. `busy` is high from the START entry until IDLE is re-entered.
- Back-to-back frames (stop bit followed immediately by a start bit) are received without loss, because IDLE is re-entered at mid stop bit.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each start, data, and stop decision is the 2-of-3 majority of samples taken at ticks `OVERSAMPLE/2-2`, `OVERSAMPLE/2-1`, and `OVERSAMPLE/2` within the bit. A single-tick glitch does not corrupt a bit.
- Undefined: a single sample is taken at tick `OVERSAMPLE/2-1`, and the majority logic is not instantiated.

## Test plan
- Reset/idle: assert `rst` with `rx_in`=1, release, run 20000 clocks -> all outputs 0, `busy`=0.
- Single byte: drive 0x55 at 9600 8N1 with `data_ready`=1 -> `data_out`=0x55, `data_valid` high for 1 clock about 15811 clocks after the start edge, no flags.
- Back-to-back with stall: send 0xA3 then 0x0F with no gap and `data_ready`=0 -> `data_out`=0xA3 is held and `overrun` pulses once at the second stop. Then raise `data_ready` -> `data_valid` clears.
- Framing error: send 0xFF with the stop bit forced 0, then line held low 3 bit times, then high -> `frame_err` pulses once, `data_valid` stays 0, `busy` stays high until the line returns high.
- Glitch rejection: 0.25-bit (416-clock) low pulse on an idle line -> return to IDLE, no `data_valid`, no flags.
- Reset mid-frame, and the majority macro:
  - Assert `rst` during bit 4 of 0x3C, release, send 0xC3 -> only 0xC3 is received.
  - With `UART_RX_MAJORITY_EN`, add a 1-tick glitch at the mid-point of bit 2 of 0x00 -> 0x00 is received.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 16x oversampled, one-deep valid/ready holding register.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around mid-bit.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 16000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = $clog2(DIV) + 1;
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(WIDTH) + 1;
`ifdef UART_RX_MAJORITY_EN
  // Decision tick is the last of the three samples, so bit boundaries shift by one tick.
  localparam int unsigned MID = OVERSAMPLE / 2;
`else
  localparam int unsigned MID = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_MID    = TW'(MID);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, state_next;
  logic [1:0]       sync;
  logic             rx_s;
  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic [TW-1:0]    tcnt;
  logic [BW-1:0]    bcnt;
  logic [WIDTH-1:0] shreg;
  logic             sample;
  logic             mid_start, mid_bit;
  logic             frame_good, frame_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_in};
  end
  assign rx_s = sync[1];

  // Divider held at zero in IDLE so ticks are phase-aligned to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        div_cnt <= '0;
    else if (state == IDLE || tick) div_cnt <= '0;
    else                            div_cnt <= div_cnt + 1'b1;
  end
  assign tick = (div_cnt == DIV_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       hist <= '1;
    else if (tick) hist <= {hist[0], rx_s};
  end
  always_comb sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  always_comb sample = rx_s;
`endif

  assign mid_start = tick && (tcnt == T_MID);
  assign mid_bit   = tick && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (mid_start) state_next = sample ? IDLE : DATA;
      DATA:    if (mid_bit && bcnt == B_LAST) state_next = STOP;
      STOP:    if (mid_bit) state_next = sample ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    frame_good = (state == STOP) && mid_bit && sample;
    frame_bad  = (state == STOP) && mid_bit && !sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        START: begin
          bcnt <= '0;
          if (tick) tcnt <= mid_start ? '0 : tcnt + 1'b1;
        end
        DATA, STOP: begin
          if (tick) tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
          if (state == DATA && mid_bit) begin
            shreg <= {sample, shreg[WIDTH-1:1]};
            bcnt  <= bcnt + 1'b1;
          end
        end
        default: tcnt <= '0;
      endcase
    end
  end

  // A simultaneous accept frees the register, so the new byte loads without an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= frame_good && data_valid && !data_ready;
      if (frame_good && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table plus randomized frames for uart_rx, scaled to a fast baud rate.
module tb_uart_rx;
  localparam int unsigned CF   = 16000000;
  localparam int unsigned BAUD = 250000;
  localparam int unsigned OS   = 16;
  localparam int unsigned W    = 8;
  localparam int unsigned DIV  = CF / (BAUD * OS);
  localparam int unsigned BT   = OS * DIV;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned LAT = (2 * W + 3) * BT / 2 + 3 + DIV;
`else
  localparam int unsigned LAT = (2 * W + 3) * BT / 2 + 3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_in = 1'b1;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, frame_err, overrun, busy;

  uart_rx #(.CLOCK_FREQ(CF), .BAUD(BAUD), .WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned  cyc = 0, ferr_cnt = 0, ovr_cnt = 0, vhi_cnt = 0, rise_cyc = 0, t0 = 0;
  logic         prev_v = 1'b0;
  logic [W-1:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid && data_ready) rx_q.push_back(data_out);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (data_valid) vhi_cnt <= vhi_cnt + 1;
    if (data_valid && !prev_v) rise_cyc <= cyc;
    prev_v <= data_valid;
  end

  int unsigned checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the holding register as an abstract slot plus the byte stream the consumer sees.
  logic [W-1:0] exp_q[$];
  int unsigned  exp_ferr = 0, exp_ovr = 0;
  logic         m_full = 1'b0;
  logic [W-1:0] m_byte = '0;
  task automatic model_frame(input logic [W-1:0] d, input logic ok, input logic rdy);
    if (rdy && m_full) begin exp_q.push_back(m_byte); m_full = 1'b0; end
    if (!ok) exp_ferr++;
    else begin
      if (!m_full) begin m_byte = d; m_full = 1'b1; end
      else exp_ovr++;
      if (rdy) begin exp_q.push_back(m_byte); m_full = 1'b0; end
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop_bit);
    rx_in = 1'b0;
    t0 = cyc;
    cycles(BT);
    for (int i = 0; i < W; i++) begin rx_in = d[i]; cycles(BT); end
    rx_in = stop_bit;
    cycles(BT);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         stop_ok;
    logic         ready;
    int unsigned  gap;
    int unsigned  d_ferr;
    int unsigned  d_ovr;
    logic         valid_after;
    logic [W-1:0] out_after;
    logic         chk_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned  f0, o0, v0, qs, n;
    logic [W-1:0] d, b;
    logic         ok, rdy;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 5, 0, 0, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'hA3, 1'b1, 1'b0, 3, 0, 0, 1'b1, 8'hA3, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 0, 0, 1, 1'b1, 8'hA3, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 2, 1, 0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 7, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 1, 0, 0, 1'b1, 8'h81, 1'b0};

    cycles(3);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    cycles(2000);
    check("idle_valid", data_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_flags", ferr_cnt + ovr_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      data_ready = vecs[i].ready;
      cycles(vecs[i].gap);
      f0 = ferr_cnt; o0 = ovr_cnt; v0 = vhi_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok);
      if (!vecs[i].stop_ok) begin
        cycles(3 * BT);
        check("break_busy", busy, 1);
        rx_in = 1'b1;
        cycles(4);
        check("break_idle", busy, 0);
      end
      model_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].ready);
      check("vec_frame_err", ferr_cnt - f0, vecs[i].d_ferr);
      check("vec_overrun", ovr_cnt - o0, vecs[i].d_ovr);
      check("vec_valid", data_valid, vecs[i].valid_after);
      if (vecs[i].valid_after) check("vec_data", data_out, vecs[i].out_after);
      if (vecs[i].chk_lat) begin
        check("latency", rise_cyc - t0, LAT);
        check("valid_width", vhi_cnt - v0, 1);
      end
    end

    // Accept and reload in the same cycle: 0x81 is held, ready rises exactly at the 0x7E load.
    data_ready = 1'b0;
    o0 = ovr_cnt;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        cycles(LAT - 1);
        data_ready = 1'b1;
        cycles(1);
        check("reload_valid", data_valid, 1);
        check("reload_data", data_out, 8'h7E);
      end
    join
    model_frame(8'h7E, 1'b1, 1'b1);
    check("reload_no_overrun", ovr_cnt - o0, 0);
    check("reload_drained", data_valid, 0);

    f0 = ferr_cnt; v0 = vhi_cnt;
    cycles(20);
    rx_in = 1'b0;
    cycles(BT / 4);
    rx_in = 1'b1;
    cycles(2 * BT);
    check("glitch_busy", busy, 0);
    check("glitch_no_valid", vhi_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    for (n = 0; n < 40; n++) begin
      d   = W'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      data_ready = rdy;
      cycles($urandom_range(0, 12));
      send_frame(d, ok);
      if (!ok) begin
        cycles($urandom_range(1, 3) * BT);
        rx_in = 1'b1;
        cycles(4);
      end
      model_frame(d, ok, rdy);
      check("rand_valid", data_valid, m_full);
      if (m_full) check("rand_hold", data_out, m_byte);
    end
    data_ready = 1'b1;
    cycles(4);
    if (m_full) begin exp_q.push_back(m_byte); m_full = 1'b0; end
    check("drain_valid", data_valid, 0);

    b = 8'h3C;
    rx_in = 1'b0;
    cycles(BT);
    for (int i = 0; i < 4; i++) begin rx_in = b[i]; cycles(BT); end
    rx_in = b[4];
    cycles(BT / 2);
    rst = 1'b1;
    cycles(2);
    check("midrst_busy", busy, 0);
    check("midrst_valid", data_valid, 0);
    rx_in = 1'b1;
    cycles(BT);
    rst = 1'b0;
    cycles(2 * BT);
    qs = rx_q.size();
    send_frame(8'hC3, 1'b1);
    model_frame(8'hC3, 1'b1, 1'b1);
    cycles(4);
    check("midrst_count", rx_q.size() - qs, 1);
    check("midrst_byte", rx_q[rx_q.size() - 1], 8'hC3);

`ifdef UART_RX_MAJORITY_EN
    qs = rx_q.size();
    rx_in = 1'b0;
    cycles(3 * BT);
    cycles(7 * DIV + DIV / 2);
    rx_in = 1'b1;
    cycles(DIV);
    rx_in = 1'b0;
    cycles(BT - 8 * DIV - DIV / 2);
    cycles(5 * BT);
    rx_in = 1'b1;
    cycles(BT);
    model_frame(8'h00, 1'b1, 1'b1);
    cycles(4);
    check("majority_count", rx_q.size() - qs, 1);
    check("majority_byte", rx_q[rx_q.size() - 1], 8'h00);
`endif

    check("total_frame_err", ferr_cnt, exp_ferr);
    check("total_overrun", ovr_cnt, exp_ovr);
    check("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check("rx_byte", rx_q[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
